// File: rtl/count_window_sequencer.sv
// rtl/count_window_sequencer.sv - timed photon-click counting bin sequencer
//
// Purpose: runs num_bins repetitions of GATE (laser_gate high, clicks counted),
// HOLD (result offered on a valid/ready handshake) and DEAD (idle spacing).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   click                      raw detector pulse, asynchronous to clk
//   start, abort               run control
//   win_len, dead_len,
//   num_bins                   run configuration, latched on start
//   laser_gate, busy, done     status
//   bin_valid/bin_ready,
//   bin_count/bin_idx/bin_sat  per-bin result handshake
module count_window_sequencer #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 24,
  parameter int BIN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             click,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic [WIN_W-1:0] dead_len,
  input  logic [BIN_W-1:0] num_bins,
  output logic             laser_gate,
  output logic             busy,
  output logic             bin_valid,
  input  logic             bin_ready,
  output logic [CNT_W-1:0] bin_count,
  output logic [BIN_W-1:0] bin_idx,
  output logic             bin_sat,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GATE = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DEAD = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIN_W-1:0] ONE_CYC = WIN_W'(1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] dead_q, dead_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [BIN_W-1:0] nbins_q, nbins_d;
  logic [BIN_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             done_q, done_d;
  logic             click_pulse;

  // sync_q[1:0] is the two-stage synchronizer; sync_q[2] only serves the edge detect.
  assign sync_d      = {sync_q[1:0], click};
  assign click_pulse = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sync_q  <= '0;
      win_q   <= '0;
      dead_q  <= '0;
      timer_q <= '0;
      nbins_q <= '0;
      idx_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      win_q   <= win_d;
      dead_q  <= dead_d;
      timer_q <= timer_d;
      nbins_q <= nbins_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    dead_d  = dead_q;
    timer_d = timer_q;
    nbins_d = nbins_q;
    idx_d   = idx_q;
    count_d = count_q;
    sat_d   = sat_q;
    done_d  = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      // Abort discards the partial bin and outranks a same-cycle handshake.
      state_d = S_IDLE;
      timer_d = '0;
      idx_d   = '0;
      count_d = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort && (num_bins != '0)) begin
            state_d = S_GATE;
            // A zero window still gives one gate cycle; store the effective length.
            win_d   = (win_len == '0) ? ONE_CYC : win_len;
            timer_d = (win_len == '0) ? ONE_CYC : win_len;
            dead_d  = dead_len;
            nbins_d = num_bins;
            idx_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
          end
        end
        S_GATE: begin
          if (click_pulse) begin
            if (count_q == CNT_MAX) sat_d = 1'b1;
            else count_d = count_q + 1'b1;
          end
          if (timer_q == ONE_CYC) state_d = S_HOLD;
          else timer_d = timer_q - 1'b1;
        end
        S_HOLD: begin
          if (bin_ready) begin
            count_d = '0;
            sat_d   = 1'b0;
            if (idx_q == nbins_q - 1'b1) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
              if (dead_q == '0) begin
                state_d = S_GATE;
                timer_d = win_q;
              end else begin
                state_d = S_DEAD;
                timer_d = dead_q;
              end
            end
          end
        end
        S_DEAD: begin
          if (timer_q == ONE_CYC) begin
            state_d = S_GATE;
            timer_d = win_q;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign laser_gate = (state_q == S_GATE);
  assign busy       = (state_q != S_IDLE);
  assign bin_valid  = (state_q == S_HOLD);
  assign bin_count  = count_q;
  assign bin_idx    = idx_q;
  assign bin_sat    = sat_q;
  assign done       = done_q;

endmodule
